// File: rtl/csa_accumulator.sv
// Streaming multi-operand accumulator: carry-save accumulation per beat, then a
// chunked carry-propagate resolve into binary on the last beat of a packet.
module csa_accumulator #(
    parameter int unsigned BITS     = 16,
    parameter int unsigned ACC_BITS = 32,
    parameter int unsigned CHUNK    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITS-1:0]     in_data,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_BITS-1:0] out_sum,
    output logic                out_overflow,
    output logic                busy
);
    localparam int unsigned NCH = ACC_BITS / CHUNK;
    localparam int unsigned CW  = $clog2(NCH) + 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCUM   = 2'd1;
    localparam logic [1:0] RESOLVE = 2'd2;
    localparam logic [1:0] HOLD    = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [ACC_BITS-1:0] s_q, s_d;
    logic [ACC_BITS-1:0] c_q, c_d;
    logic [ACC_BITS-1:0] sum_q, sum_d;
    logic                cy_q, cy_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                ovf_q, ovf_d;

    logic                accept;
    logic [ACC_BITS-1:0] z;
    logic [ACC_BITS-1:0] maj;
    logic [CHUNK:0]      chunk;

    assign in_ready     = (state_q == IDLE) || (state_q == ACCUM);
    assign accept       = in_valid && in_ready;
    assign out_valid    = (state_q == HOLD);
    assign busy         = (state_q != IDLE);
    assign out_sum      = sum_q;
    assign out_overflow = ovf_q;

    assign z     = ACC_BITS'(in_data);
    assign maj   = (s_q & c_q) | (s_q & z) | (c_q & z);
    assign chunk = {1'b0, s_q[CHUNK-1:0]} + {1'b0, c_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, cy_q};

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        c_d     = c_q;
        sum_d   = sum_q;
        cy_d    = cy_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    s_d     = z;
                    c_d     = '0;
                    ovf_d   = 1'b0;
                    cy_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = in_last ? RESOLVE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    s_d   = s_q ^ c_q ^ z;
                    // The majority MSB would carry out at weight 2^ACC_BITS: record it as overflow.
                    c_d   = {maj[ACC_BITS-2:0], 1'b0};
                    ovf_d = ovf_q | maj[ACC_BITS-1];
                    cy_d  = 1'b0;
                    cnt_d = '0;
                    if (in_last) state_d = RESOLVE;
                end
            end
            RESOLVE: begin
                // S and C shift down one chunk per cycle; results enter sum from the top,
                // so after NCH cycles chunk 0 sits in the LSBs.
                s_d   = s_q >> CHUNK;
                c_d   = c_q >> CHUNK;
                sum_d = {chunk[CHUNK-1:0], sum_q[ACC_BITS-1:CHUNK]};
                cy_d  = chunk[CHUNK];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(NCH - 1)) begin
                    ovf_d   = ovf_q | chunk[CHUNK];
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            c_q     <= '0;
            sum_q   <= '0;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            cy_q    <= cy_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_csa_accumulator.sv
// Scoreboard bench for csa_accumulator: a reference sum is queued per packet
// and compared when the DUT hands its result off.
module tb_csa_accumulator;
    localparam int unsigned BITS     = 8;
    localparam int unsigned ACC_BITS = 16;
    localparam int unsigned CHUNK    = 4;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [BITS-1:0]     in_data;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic [ACC_BITS-1:0] out_sum;
    logic                out_overflow;
    logic                busy;

    csa_accumulator #(
        .BITS     (BITS),
        .ACC_BITS (ACC_BITS),
        .CHUNK    (CHUNK)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_overflow (out_overflow),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [16:0] exp_q[$];
    longint unsigned model_acc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: compare each result on the cycle it is handed off.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                check_eq("out_sum", 32'(out_sum), 32'(e[15:0]));
                check_eq("out_overflow", 32'(out_overflow), 32'(e[16]));
            end
        end
    end

    task automatic send(input logic [BITS-1:0] d, input logic last, input logic first);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 100) check_eq("in_ready_timeout", 32'd0, 32'd1);
        if (first) model_acc = 0;
        model_acc += longint'(d);
        if (last) exp_q.push_back({model_acc >= 65536, model_acc[15:0]});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (!out_valid && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        while (out_valid && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 100 || out_valid) check_eq("result_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int cycles;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // 1: reset state
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_out_sum", 32'(out_sum), 32'd0);
        rst_n = 1'b1;
        idle(2);
        check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

        // 2: back-to-back 3,5,7 with latency and pulse width
        send(8'd3, 1'b0, 1'b1);
        send(8'd5, 1'b0, 1'b0);
        send(8'd7, 1'b1, 1'b0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_eq("resolve_in_ready", 32'(in_ready), 32'd0);
        check_eq("resolve_busy", 32'(busy), 32'd1);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check_eq("latency", 32'(cycles), 32'd4);
        @(posedge clk);
        #1;
        check_eq("out_valid_one_cycle", 32'(out_valid), 32'd0);
        check_eq("back_to_idle_busy", 32'(busy), 32'd0);

        // 3: 300 x 0xFF wraps once
        for (int i = 0; i < 300; i++) send(8'hFF, i == 299, i == 0);
        idle(0);
        wait_done();

        // 4: single-beat packet
        send(8'hAB, 1'b1, 1'b1);
        idle(0);
        wait_done();

        // 5: gapped beats, then back-pressure
        idle($urandom_range(0, 3));
        send(8'hFF, 1'b0, 1'b1);
        idle($urandom_range(1, 4));
        out_ready = 1'b0;
        send(8'h01, 1'b1, 1'b0);
        idle(5);
        check_eq("hold_out_valid_rise", 32'(out_valid), 32'd1);
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (i % 3 == 0) begin
                check_eq("hold_out_valid", 32'(out_valid), 32'd1);
                check_eq("hold_out_sum", 32'(out_sum), 32'h0100);
                check_eq("hold_in_ready", 32'(in_ready), 32'd0);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_done();

        // 6: reset during resolve abandons the packet
        send(8'd9, 1'b0, 1'b1);
        send(8'd10, 1'b1, 1'b0);
        idle(1);
        #2 rst_n = 1'b0;
        void'(exp_q.pop_back());
        #1;
        check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(8);
        check_eq("no_stale_result", 32'(out_valid), 32'd0);
        send(8'd1, 1'b0, 1'b1);
        send(8'd2, 1'b1, 1'b0);
        idle(0);
        wait_done();

        idle(2);
        check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
